// File: rtl/within_throughout_checker.sv
// Hardware monitor for "guard throughout (inner within outer)" across N_CH channels.
// Every outer window is graded PASS or FAIL with a cause; aggregate pass/fail counters saturate.
module within_throughout_checker #(
   parameter int unsigned N_CH      = 4,
   parameter int unsigned INNER_LEN = 2,
   parameter int unsigned MAX_OUTER = 16,
   parameter int unsigned CNT_W     = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                en,
   input  logic                clr_cnt,
   input  logic [N_CH-1:0]     guard,
   input  logic [N_CH-1:0]     inner,
   input  logic [N_CH-1:0]     outer,
   output logic [N_CH-1:0]     busy,
   output logic [N_CH-1:0]     pass,
   output logic [N_CH-1:0]     fail,
   output logic [2*N_CH-1:0]   fail_code,
   output logic [CNT_W-1:0]    pass_cnt,
   output logic [CNT_W-1:0]    fail_cnt
);

   localparam int unsigned PC_W  = $clog2(N_CH + 1);
   localparam int unsigned SUM_W = CNT_W + PC_W;
   localparam logic [1:0] CODE_GUARD    = 2'b01;
   localparam logic [1:0] CODE_NO_INNER = 2'b10;
   localparam logic [1:0] CODE_TIMEOUT  = 2'b11;
   localparam logic [7:0] INNER_TGT     = 8'(INNER_LEN);
   localparam logic [8:0] OUTER_MAX     = 9'(MAX_OUTER);
   localparam logic [SUM_W-1:0] CNT_MAX = {{PC_W{1'b0}}, {CNT_W{1'b1}}};

   typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_DRAIN} state_t;

   for (genvar c = 0; c < N_CH; c++) begin : g_ch
      state_t     state;
      logic [7:0] olen;
      logic [7:0] irun;
      logic [7:0] irun_inc;
      logic       iseen;
      logic       busy_q;
      logic       pass_q;
      logic       fail_q;
      logic [1:0] code_q;

      // inner run length saturates at the target so it never wraps in long windows
      assign irun_inc = (irun == INNER_TGT) ? irun : irun + 8'd1;

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            state  <= S_IDLE;
            olen   <= 8'd0;
            irun   <= 8'd0;
            iseen  <= 1'b0;
            busy_q <= 1'b0;
            pass_q <= 1'b0;
            fail_q <= 1'b0;
            code_q <= 2'b00;
         end else begin
            pass_q <= 1'b0;
            fail_q <= 1'b0;
            case (state)
               S_IDLE: begin
                  if (en && outer[c]) begin
                     olen   <= 8'd1;
                     irun   <= 8'(inner[c]);
                     iseen  <= (INNER_LEN == 32'd1) && inner[c];
                     busy_q <= 1'b1;
                     if (!guard[c]) begin
                        fail_q <= 1'b1;
                        code_q <= CODE_GUARD;
                        state  <= S_DRAIN;
                     end else begin
                        state  <= S_ACTIVE;
                     end
                  end
               end
               S_ACTIVE: begin
                  if (!outer[c]) begin
                     pass_q <= iseen;
                     fail_q <= !iseen;
                     if (!iseen) code_q <= CODE_NO_INNER;
                     busy_q <= 1'b0;
                     state  <= S_IDLE;
                  end else if (!guard[c]) begin
                     fail_q <= 1'b1;
                     code_q <= CODE_GUARD;
                     state  <= S_DRAIN;
                  end else if (({1'b0, olen} + 9'd1) > OUTER_MAX) begin
                     fail_q <= 1'b1;
                     code_q <= CODE_TIMEOUT;
                     state  <= S_DRAIN;
                  end else begin
                     olen <= olen + 8'd1;
                     irun <= inner[c] ? irun_inc : 8'd0;
                     if (inner[c] && (irun_inc == INNER_TGT)) iseen <= 1'b1;
                  end
               end
               S_DRAIN: begin
                  if (!outer[c]) begin
                     busy_q <= 1'b0;
                     state  <= S_IDLE;
                  end
               end
               default: begin
                  busy_q <= 1'b0;
                  state  <= S_IDLE;
               end
            endcase
         end
      end

      assign busy[c]          = busy_q;
      assign pass[c]          = pass_q;
      assign fail[c]          = fail_q;
      assign fail_code[2*c+:2] = code_q;
   end

   logic [PC_W-1:0]  pass_pc;
   logic [PC_W-1:0]  fail_pc;
   logic [SUM_W-1:0] pass_sum;
   logic [SUM_W-1:0] fail_sum;

   // sums are widened so several same-cycle pulses cannot wrap past saturation
   always_comb begin
      pass_pc = '0;
      fail_pc = '0;
      for (int i = 0; i < N_CH; i++) begin
         pass_pc = pass_pc + PC_W'(pass[i]);
         fail_pc = fail_pc + PC_W'(fail[i]);
      end
      pass_sum = SUM_W'(pass_cnt) + SUM_W'(pass_pc);
      fail_sum = SUM_W'(fail_cnt) + SUM_W'(fail_pc);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pass_cnt <= '0;
         fail_cnt <= '0;
      end else if (clr_cnt) begin
         pass_cnt <= '0;
         fail_cnt <= '0;
      end else begin
         pass_cnt <= (pass_sum > CNT_MAX) ? {CNT_W{1'b1}} : pass_sum[CNT_W-1:0];
         fail_cnt <= (fail_sum > CNT_MAX) ? {CNT_W{1'b1}} : fail_sum[CNT_W-1:0];
      end
   end

endmodule

// File: tb/tb_within_throughout_checker.sv
// Bench for within_throughout_checker: vector table through an expectation queue,
// plus hand sequences for reset abort and an INNER_LEN=1 / CNT_W=2 instance.
module tb_within_throughout_checker;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic        en, clr_cnt;
   logic [3:0]  guard, inner, outer;
   logic [3:0]  busy, pass, fail;
   logic [7:0]  fail_code;
   logic [15:0] pass_cnt, fail_cnt;

   logic        en2, clr2;
   logic [3:0]  guard2, inner2, outer2;
   logic [3:0]  busy2, pass2, fail2;
   logic [7:0]  code2;
   logic [1:0]  pcnt2, fcnt2;

   within_throughout_checker #(.N_CH(4), .INNER_LEN(2), .MAX_OUTER(16), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .en(en), .clr_cnt(clr_cnt),
      .guard(guard), .inner(inner), .outer(outer),
      .busy(busy), .pass(pass), .fail(fail), .fail_code(fail_code),
      .pass_cnt(pass_cnt), .fail_cnt(fail_cnt));

   within_throughout_checker #(.N_CH(4), .INNER_LEN(1), .MAX_OUTER(16), .CNT_W(2)) dut2 (
      .clk(clk), .rst(rst), .en(en2), .clr_cnt(clr2),
      .guard(guard2), .inner(inner2), .outer(outer2),
      .busy(busy2), .pass(pass2), .fail(fail2), .fail_code(code2),
      .pass_cnt(pcnt2), .fail_cnt(fcnt2));

   typedef struct {
      logic        en;
      logic        clr;
      logic [3:0]  g;
      logic [3:0]  i;
      logic [3:0]  o;
      logic [3:0]  busy;
      logic [3:0]  pass;
      logic [3:0]  fail;
      logic [7:0]  code;
      logic        chk_cnt;
      logic [15:0] pc;
      logic [15:0] fc;
   } vec_t;

   vec_t vecs[$];
   vec_t exp_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   function automatic void add(input logic en_v, input logic clr_v, input logic [3:0] g_v,
                               input logic [3:0] i_v, input logic [3:0] o_v,
                               input logic [3:0] busy_v, input logic [3:0] pass_v,
                               input logic [3:0] fail_v, input logic [7:0] code_v,
                               input logic chk_v = 1'b0, input logic [15:0] pc_v = 16'd0,
                               input logic [15:0] fc_v = 16'd0);
      vec_t v;
      v.en = en_v; v.clr = clr_v; v.g = g_v; v.i = i_v; v.o = o_v;
      v.busy = busy_v; v.pass = pass_v; v.fail = fail_v; v.code = code_v;
      v.chk_cnt = chk_v; v.pc = pc_v; v.fc = fc_v;
      vecs.push_back(v);
   endfunction

   task automatic step2(input logic [3:0] o_v, input logic [3:0] i_v, input logic [3:0] g_v);
      @(negedge clk);
      outer2 = o_v; inner2 = i_v; guard2 = g_v;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      vec_t e;

      // idle after reset
      for (int k = 0; k < 10; k++) add(1, 0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 8'h00, 1, 0, 0);
      // ch0 pass: inner high in window cycles 2-3
      add(1, 0, 4'h1, 4'h0, 4'h1, 4'h1, 4'h0, 4'h0, 8'h00);
      add(1, 0, 4'h1, 4'h1, 4'h1, 4'h1, 4'h0, 4'h0, 8'h00);
      add(1, 0, 4'h1, 4'h1, 4'h1, 4'h1, 4'h0, 4'h0, 8'h00);
      add(1, 0, 4'h1, 4'h0, 4'h1, 4'h1, 4'h0, 4'h0, 8'h00);
      add(1, 0, 4'h1, 4'h0, 4'h1, 4'h1, 4'h0, 4'h0, 8'h00);
      add(1, 0, 4'h1, 4'h0, 4'h0, 4'h0, 4'h1, 4'h0, 8'h00, 1, 0, 0);
      add(1, 0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 8'h00, 1, 1, 0);
      // ch0 guard drop in window cycle 3, single verdict
      add(1, 0, 4'h1, 4'h0, 4'h1, 4'h1, 4'h0, 4'h0, 8'h00);
      add(1, 0, 4'h1, 4'h1, 4'h1, 4'h1, 4'h0, 4'h0, 8'h00);
      add(1, 0, 4'h0, 4'h1, 4'h1, 4'h1, 4'h0, 4'h1, 8'h01, 1, 1, 0);
      add(1, 0, 4'h1, 4'h0, 4'h1, 4'h1, 4'h0, 4'h0, 8'h01, 1, 1, 1);
      add(1, 0, 4'h1, 4'h0, 4'h1, 4'h1, 4'h0, 4'h0, 8'h01);
      add(1, 0, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 8'h01, 1, 1, 1);
      add(1, 0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 8'h01, 1, 1, 1);
      // ch1 inner high before window and in cycle 1 only
      add(1, 0, 4'h2, 4'h2, 4'h0, 4'h0, 4'h0, 4'h0, 8'h01);
      add(1, 0, 4'h2, 4'h2, 4'h2, 4'h2, 4'h0, 4'h0, 8'h01);
      add(1, 0, 4'h2, 4'h0, 4'h2, 4'h2, 4'h0, 4'h0, 8'h01);
      add(1, 0, 4'h2, 4'h0, 4'h2, 4'h2, 4'h0, 4'h0, 8'h01);
      add(1, 0, 4'h2, 4'h0, 4'h2, 4'h2, 4'h0, 4'h0, 8'h01);
      add(1, 0, 4'h2, 4'h0, 4'h0, 4'h0, 4'h0, 4'h2, 8'h09, 1, 1, 1);
      add(1, 0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 8'h09, 1, 1, 2);
      // ch3: en low blocks opening, en low mid-window does not abort
      add(0, 0, 4'h8, 4'h8, 4'h8, 4'h0, 4'h0, 4'h0, 8'h09);
      add(0, 0, 4'h8, 4'h8, 4'h8, 4'h0, 4'h0, 4'h0, 8'h09);
      add(0, 0, 4'h8, 4'h8, 4'h0, 4'h0, 4'h0, 4'h0, 8'h09);
      add(1, 0, 4'h8, 4'h8, 4'h8, 4'h8, 4'h0, 4'h0, 8'h09);
      add(0, 0, 4'h8, 4'h8, 4'h8, 4'h8, 4'h0, 4'h0, 8'h09);
      add(0, 0, 4'h8, 4'h0, 4'h0, 4'h0, 4'h8, 4'h0, 8'h09, 1, 1, 2);
      add(1, 0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 8'h09, 1, 2, 2);
      // ch2 timeout on the 17th outer edge, busy until outer falls
      for (int k = 1; k <= 20; k++)
         add(1, 0, 4'h4, 4'h4, 4'h4, 4'h4, 4'h0, (k == 17) ? 4'h4 : 4'h0,
             (k >= 17) ? 8'h39 : 8'h09);
      add(1, 0, 4'h4, 4'h4, 4'h0, 4'h0, 4'h0, 4'h0, 8'h39, 1, 2, 3);
      add(1, 0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 8'h39, 1, 2, 3);
      // ch0+ch3 pass together, then clr_cnt collides with a fail increment
      add(1, 1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 8'h39, 1, 0, 0);
      add(1, 0, 4'h9, 4'h9, 4'h9, 4'h9, 4'h0, 4'h0, 8'h39);
      add(1, 0, 4'h9, 4'h9, 4'h9, 4'h9, 4'h0, 4'h0, 8'h39);
      add(1, 0, 4'h9, 4'h9, 4'h9, 4'h9, 4'h0, 4'h0, 8'h39);
      add(1, 0, 4'h9, 4'h9, 4'h0, 4'h0, 4'h9, 4'h0, 8'h39, 1, 0, 0);
      add(1, 0, 4'h0, 4'h0, 4'h2, 4'h2, 4'h0, 4'h2, 8'h35, 1, 2, 0);
      add(1, 1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 8'h35, 1, 0, 0);
      add(1, 0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 8'h35, 1, 0, 0);

      rst = 1'b1;
      en = 1'b1; clr_cnt = 1'b0; guard = '0; inner = '0; outer = '0;
      en2 = 1'b1; clr2 = 1'b0; guard2 = '0; inner2 = '0; outer2 = '0;
      #12;
      chk("reset.busy", 32'(busy), 32'h0);
      chk("reset.code", 32'(fail_code), 32'h0);
      chk("reset.cnt", {pass_cnt, fail_cnt}, 32'h0);
      @(negedge clk);
      rst = 1'b0;

      foreach (vecs[k]) begin
         @(negedge clk);
         en = vecs[k].en; clr_cnt = vecs[k].clr;
         guard = vecs[k].g; inner = vecs[k].i; outer = vecs[k].o;
         exp_q.push_back(vecs[k]);
         @(posedge clk);
         #1;
         e = exp_q.pop_front();
         chk($sformatf("v%0d.busy", k), 32'(busy), 32'(e.busy));
         chk($sformatf("v%0d.pass", k), 32'(pass), 32'(e.pass));
         chk($sformatf("v%0d.fail", k), 32'(fail), 32'(e.fail));
         chk($sformatf("v%0d.code", k), 32'(fail_code), 32'(e.code));
         if (e.chk_cnt) begin
            chk($sformatf("v%0d.pass_cnt", k), 32'(pass_cnt), 32'(e.pc));
            chk($sformatf("v%0d.fail_cnt", k), 32'(fail_cnt), 32'(e.fc));
         end
      end

      // reset mid-window aborts without a verdict
      @(negedge clk);
      en = 1'b1; clr_cnt = 1'b0; guard = 4'h1; inner = 4'h1; outer = 4'h1;
      @(posedge clk);
      #1;
      chk("abort.open_busy", 32'(busy), 32'h1);
      @(negedge clk);
      rst = 1'b1; outer = 4'h0;
      #1;
      chk("abort.busy", 32'(busy), 32'h0);
      chk("abort.code", 32'(fail_code), 32'h0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      chk("abort.verdict", {28'h0, pass | fail}, 32'h0);
      chk("abort.busy2", 32'(busy), 32'h0);

      // INNER_LEN=1 instance: same ch1 stimulus passes; five passes saturate a 2-bit counter
      step2(4'h0, 4'h2, 4'h2);
      step2(4'h2, 4'h2, 4'h2);
      chk("il1.busy", 32'(busy2), 32'h2);
      step2(4'h2, 4'h0, 4'h2);
      step2(4'h2, 4'h0, 4'h2);
      step2(4'h2, 4'h0, 4'h2);
      step2(4'h0, 4'h0, 4'h2);
      chk("il1.pass", 32'(pass2), 32'h2);
      chk("il1.fail", 32'(fail2), 32'h0);
      step2(4'h0, 4'h0, 4'h0);
      chk("il1.pass_cnt", 32'(pcnt2), 32'h1);
      step2(4'hf, 4'hf, 4'hf);
      chk("il1.busy_all", 32'(busy2), 32'hf);
      step2(4'h0, 4'h0, 4'h0);
      chk("il1.pass_all", 32'(pass2), 32'hf);
      step2(4'h0, 4'h0, 4'h0);
      chk("sat.pass_cnt", 32'(pcnt2), 32'h3);
      chk("sat.fail_cnt", 32'(fcnt2), 32'h0);
      chk("sat.code", 32'(code2), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/within_throughout_checker.md
Name: within_throughout_checker

Overview:
- Synthesizable, multi-channel RTL monitor for the temporal relation "guard throughout (inner within outer)".
- Each channel watches its own three level signals and grades every outer window as PASS or FAIL, with a failure cause.
- Results go out as one-cycle pulses, per-channel fail codes and aggregate saturating counters.
- Sits beside the assertion-based benches as a hardware equivalent that can run on emulation/FPGA, where SVA is unavailable.

Parameters:
- N_CH, 4, number of independent channels.
- INNER_LEN, 2, consecutive inner-high cycles (counted inside the window) needed to satisfy "within"; range 1..255.
- MAX_OUTER, 16, maximum legal outer-window length in cycles; exceeding it is a timeout; must be >= INNER_LEN.
- CNT_W, 16, width of the aggregate pass/fail counters.

Ports:
- clk  in  1  sampling clock; all inputs sampled on posedge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  global enable; when 0, channels in IDLE do not open new windows; open windows keep running.
- clr_cnt  in  1  synchronous clear of pass_cnt/fail_cnt.
- guard  in  N_CH  per-channel "throughout" condition.
- inner  in  N_CH  per-channel inner event.
- outer  in  N_CH  per-channel outer window; a window is a contiguous run of outer=1.
- busy  out  N_CH  channel has an open window (ACTIVE or DRAIN).
- pass  out  N_CH  one-cycle pulse: window graded PASS.
- fail  out  N_CH  one-cycle pulse: window graded FAIL.
- fail_code  out  2*N_CH  cause, channel c at [2c+1:2c]: 01 GUARD, 10 NO_INNER, 11 TIMEOUT; holds last value until the next fail on that channel.
- pass_cnt  out  CNT_W  total PASS pulses, saturating.
- fail_cnt  out  CNT_W  total FAIL pulses, saturating.

Behaviour:
- Reset: every channel is in IDLE; busy, pass, fail, fail_code, pass_cnt, fail_cnt and all internal counters are 0.
- Per-channel FSM, states IDLE, ACTIVE, DRAIN; counters olen (8 bits) and irun (8 bits, saturating at INNER_LEN); flag iseen.
- IDLE -> ACTIVE: taken at an edge with en=1 and outer=1.
  - At that edge olen=1.
  - irun=inner, so an inner that was already high counts only from the window's first cycle.
  - iseen=(INNER_LEN==1 && inner).
  - If guard=0 on that same edge, the window fails GUARD and goes to DRAIN instead.
- ACTIVE, outer=1 each edge, priority in this order:
  - guard=0: FAIL GUARD, go to DRAIN.
  - else olen+1 > MAX_OUTER: FAIL TIMEOUT, go to DRAIN.
  - else: olen++; irun = inner ? irun+1 : 0; iseen is set when irun reaches INNER_LEN.
- ACTIVE, outer=0: the window closes.
  - iseen=1: PASS. Otherwise FAIL NO_INNER.
  - Go to IDLE. Guard and inner are ignored on this edge.
- DRAIN: no grading. Go to IDLE on the first edge with outer=0. One window produces exactly one verdict.
- Latency: pass/fail/fail_code are registered and assert in the cycle after the deciding edge. busy follows state with the same latency.
- Back-to-back windows: a new window can open no earlier than the edge after the IDLE return, so at least one outer=0 cycle always separates windows.
- Counters:
  - pass_cnt and fail_cnt add popcount(pass) and popcount(fail) each cycle.
  - Both saturate at 2^CNT_W-1.
  - clr_cnt has priority over increment; the same-cycle increment is discarded.
- en deasserted mid-window does not abort the window.
- Reset asserted mid-window aborts immediately with no verdict.

Test Plan:
- rst pulse, then outer=inner=guard=0 for 10 cycles -> no pass/fail pulses; busy=0; counters stay 0.
- ch0 (defaults INNER_LEN=2): guard=1, outer=1 for 5 cycles, inner=1 in window cycles 2-3 -> single pass[0] the cycle after outer falls; pass_cnt=1.
- ch0: outer=1 for 5 cycles, inner high in cycles 2-3, guard drops in cycle 3 -> fail[0] at cycle 4, fail_code[1:0]=01; no second verdict when outer falls; fail_cnt=1.
- ch1: guard=1, outer=1 for 4 cycles, inner high only in the cycle before the window and window cycle 1, then low -> fail[1] after close, code 10; with INNER_LEN=1 the same stimulus passes.
- ch2: guard=1, inner=1, outer held 20 cycles with MAX_OUTER=16 -> fail[2] code 11 one cycle after the 17th outer edge; busy[2] stays 1 until outer falls.
- Channels 0 and 3 pass on the same cycle, then clr_cnt is pulsed together with a fail -> pass_cnt=2, then both counters read 0; with CNT_W=2, five passes leave pass_cnt=3.
